// File: rtl/switch_bounce_pkg.sv
// Shared types and constants for the bouncing-switch stimulus generator
// and the other self-test stimulus blocks that reuse its LFSR.
package switch_bounce_pkg;

  typedef enum logic [1:0] {
    STABLE,
    BOUNCE,
    SETTLE
  } sbg_state_t;

  localparam logic [15:0] LFSR_RESET_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that free-runs every cycle; a synchronous load has
// priority, and an all-zero seed (the lock-up state) is replaced.
module lfsr16
  import switch_bounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= LFSR_RESET_SEED;
    end else if (load) begin
      r_q <= (seed == 16'h0000) ? LFSR_RESET_SEED : seed;
    end else begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Turns a clean press/release level into a bouncing switch waveform:
// first edge, 2N pseudo-random glitch toggles, a settle hold, then done.
module switch_bounce_gen #(
  parameter int MAX_BOUNCES = 7,
  parameter int SEG_MIN     = 4,
  parameter int SEG_RAND_W  = 4,
  parameter int SETTLE      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        press,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        sw_out,
  output logic        busy,
  output logic        done
);
  import switch_bounce_pkg::*;

  localparam int SEG_W = $clog2(SEG_MIN + (1 << SEG_RAND_W));
  localparam int ST_W  = $clog2(SETTLE + 1);

  logic [15:0]      w_lfsr;
  logic             w_unused_lfsr;
  logic [3:0]       w_n;
  logic [SEG_W-1:0] w_seg_load;

  sbg_state_t       r_state;
  logic             r_sw_out;
  logic             r_busy;
  logic             r_done;
  logic             r_target;
  logic [4:0]       r_bnc_cnt;
  logic [SEG_W-1:0] r_seg_cnt;
  logic [ST_W-1:0]  r_settle_cnt;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .seed (seed),
    .q    (w_lfsr)
  );

  // Only a few LFSR bits feed this block; the rest are consumed here.
  assign w_unused_lfsr = ^w_lfsr;

  assign w_n        = (w_lfsr[3:0] > 4'(MAX_BOUNCES)) ? 4'(MAX_BOUNCES) : w_lfsr[3:0];
  assign w_seg_load = SEG_W'(SEG_MIN) + SEG_W'(w_lfsr[SEG_RAND_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= STABLE;
      r_sw_out     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_target     <= 1'b0;
      r_bnc_cnt    <= '0;
      r_seg_cnt    <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        STABLE: begin
          if (press != r_sw_out) begin
            r_target <= press;
            r_sw_out <= ~r_sw_out;
            r_busy   <= 1'b1;
            if (w_n != 4'd0) begin
              r_bnc_cnt <= {w_n, 1'b0};
              r_seg_cnt <= w_seg_load;
              r_state   <= BOUNCE;
            end else begin
              r_settle_cnt <= ST_W'(SETTLE);
              r_state      <= switch_bounce_pkg::SETTLE;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        BOUNCE: begin
          // An even toggle count leaves sw_out on the target after the burst.
          if (r_seg_cnt == SEG_W'(1)) begin
            r_sw_out  <= ~r_sw_out;
            r_seg_cnt <= w_seg_load;
            r_bnc_cnt <= r_bnc_cnt - 5'd1;
            if (r_bnc_cnt == 5'd1) begin
              r_settle_cnt <= ST_W'(SETTLE);
              r_state      <= switch_bounce_pkg::SETTLE;
            end
          end else begin
            r_seg_cnt <= r_seg_cnt - SEG_W'(1);
          end
        end
        switch_bounce_pkg::SETTLE: begin
          r_sw_out <= r_target;
          if (r_settle_cnt == ST_W'(1)) begin
            r_done  <= 1'b1;
            r_state <= STABLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - ST_W'(1);
          end
        end
        default: r_state <= STABLE;
      endcase
    end
  end

  assign sw_out = r_sw_out;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: doc/switch_bounce_gen.md
# switch_bounce_gen

Generates a realistic bouncing switch waveform from a clean press/release command. This is the stimulus-side counterpart of the debouncer. It drives the debouncer's `sw` input on FPGA self-test builds and in hardware-in-loop benches. Each commanded level change becomes an edge burst with a pseudo-random bounce count and pseudo-random segment widths, followed by a settle period and a one-cycle completion pulse.

## Interface
- `MAX_BOUNCES`, default 7: upper clamp on glitches per transition, range 0..15.
- `SEG_MIN`, default 4: minimum cycles per bounce segment, must be ≥1.
- `SEG_RAND_W`, default 4: random bits added to each segment length.
- `SETTLE`, default 32: cycles the target level is held before the transition completes, must be ≥1.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `press`, input, 1: clean commanded switch level, synchronous to `clk`.
- `seed_load`, input, 1: load `seed` into the LFSR on this cycle.
- `seed`, input, 16: LFSR seed value. A value of 0 is replaced by 16'hACE1.
- `sw_out`, output, 1: bouncing switch level, registered.
- `busy`, output, 1: high from the first edge of a transition through the last settle cycle.
- `done`, output, 1: one-cycle pulse when a transition completes.

## Operation
- The block has a 16-bit Galois LFSR.
  - Taps are 16'hB400.
  - It advances every cycle.
  - `seed_load` takes priority over advancing and is accepted in any state.
- State `STABLE`:
  - `busy`=0 and `sw_out` is held.
  - If `press` != `sw_out`:
    - Latch `target`=`press`.
    - Latch N = min(lfsr[3:0], `MAX_BOUNCES`).
    - Toggle `sw_out`, which is the first edge and goes toward `target`.
    - If N>0, go to `BOUNCE`. If N=0, go to `SETTLE`.
- State `BOUNCE`:
  - Load the segment counter with `SEG_MIN` + lfsr[`SEG_RAND_W`-1:0].
  - When a segment expires, toggle `sw_out` and reload the segment counter from the current LFSR value.
  - Perform exactly 2N toggles after the first edge, so `sw_out` always ends at `target`.
  - After the last toggle, go to `SETTLE`.
- State `SETTLE`:
  - Hold `sw_out`=`target` for `SETTLE` cycles.
  - On the final cycle, assert `done` and return to `STABLE`.
- `press` is ignored in `BOUNCE` and `SETTLE`.
  - If `press` differs from `sw_out` on return to `STABLE`, the next transition starts on the following cycle.
  - No command is lost as long as the level is still held.
- Widths:
  - Bounce counter: 5 bits, holding up to 2·15.
  - Segment counter: clog2(`SEG_MIN`+2^`SEG_RAND_W`) bits.
  - Settle counter: clog2(`SETTLE`+1) bits.
  - No counter wraps. Each counter saturates or reloads only as specified above.

## Timing
- Reset values:
  - `sw_out`=0, `busy`=0, `done`=0.
  - State=`STABLE`.
  - LFSR=16'hACE1.
- Reset mid-transition:
  - `sw_out` returns to 0 asynchronously.
  - The burst is abandoned and no `done` is issued.
- Latency when `press` changes with a sample at edge t:
  - The first edge appears on `sw_out` after edge t.
  - `busy` rises on the same edge as the first edge.
- Segment length lies in [`SEG_MIN`, `SEG_MIN`+2^`SEG_RAND_W`-1] cycles. Each toggle follows exactly one segment.
- With N=0, `done` is high on the cycle `SETTLE` cycles after the first edge. `busy` falls on the edge after `done`.
- Simultaneous events:
  - `seed_load` during `BOUNCE` affects only segments loaded after the load.
  - A `press` change on the same edge as the `done` cycle is evaluated next cycle in `STABLE`.

## Structure
- Package `switch_bounce_pkg` contains:
  - The state enum: `STABLE`, `BOUNCE`, `SETTLE`.
  - `LFSR_RESET_SEED`=16'hACE1.
  - `LFSR_TAPS`=16'hB400.
- Sub-module `lfsr16` provides the Galois LFSR.
  - Ports: `clk`, `rst`, `load`, `seed`, `q`.
  - It has zero-seed substitution and is reused by other self-test stimulus blocks.

## Test plan
- Reset release with `press`=0 held for 100 cycles -> `sw_out`=0, `busy`=0, `done` never asserted.
- `MAX_BOUNCES`=0, `SETTLE`=32, `press` 0→1 sampled at cycle 10:
  - `sw_out`=1 from cycle 11.
  - `done` is high at cycle 43 only.
  - `busy` is high on cycles 11–43.
- Default parameters, `seed`=16'h0001 loaded, `press` rise:
  - The toggle count equals 2·min(lfsr[3:0],7)+1 per the bench LFSR model.
  - Every segment is 4–19 cycles.
  - The final `sw_out` is 1.
- `press` pulses 1 for 3 cycles during `BOUNCE` and returns to 0:
  - The rise burst completes.
  - A fall burst starts on the cycle after `done`.
  - `sw_out` ends at 0.
- Assert `rst` in the middle of a `BOUNCE` segment:
  - `sw_out`=0 immediately and LFSR=16'hACE1.
  - No `done`.
  - A new press after release behaves as in the first cycle-exact scenario.
- `seed_load` with `seed`=0 -> LFSR reads 16'hACE1 on the next cycle.
